// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter; never below one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_cla.sv
// Parallel-prefix (Kogge-Stone) carry-lookahead adder, purely combinational.
module carry_lookahead_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_gg;
  logic [WIDTH-1:0] w_pg;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carry-in folded into bit 0 generate so the prefix tree yields every carry.
  always_comb begin
    w_gg    = w_g;
    w_pg    = w_p;
    w_gg[0] = w_g[0] | (w_p[0] & i_c_in);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = WIDTH - 1; i >= d; i--) begin
        w_gg[i] = w_gg[i] | (w_pg[i] & w_gg[i-d]);
        w_pg[i] = w_pg[i] & w_pg[i-d];
      end
    end
    w_c = {w_gg, i_c_in};
  end

  assign o_sum   = w_p ^ w_c[WIDTH-1:0];
  assign o_c_out = w_c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned multi-cycle shift-and-add multiplier, one iteration per clock,
// valid/ready handshakes on both operand and product sides.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_c_out;
  logic [2*WIDTH-1:0] w_shifted;
  logic               w_last;

  assign w_addend = r_lo[0] ? r_mcand : '0;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .i_a     (r_hi),
    .i_b     (w_addend),
    .i_c_in  (1'b0),
    .o_sum   (w_sum),
    .o_c_out (w_c_out)
  );

  // {c_out, sum, lo} >> 1: carry-out lands in the top bit, never dropped.
  assign w_shifted = {w_c_out, w_sum, r_lo[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          {r_hi, r_lo} <= w_shifted;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_shifted;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector and random regression bench for shift_add_multiplier (WIDTH=32).
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshakes must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (in_ready && out_valid) begin
        bad++;
        $display("FAIL overlap: in_ready=%b out_valid=%b expected not both", in_ready, out_valid);
      end
    end
  end

  task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic [63:0] exp,
                       input int stall, input bit noise);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("in_ready_before", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    in_valid = noise; a = $urandom; b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (noise) begin a = $urandom; b = $urandom; end
    end
    chk("latency", 64'(cyc), 64'd32);
    chk("product", product, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (noise) begin a = $urandom; b = $urandom; end
      chk("stall_product", product, exp);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_in_ready", {63'd0, in_ready}, 64'd1);
    chk("handoff_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_product", product, exp);
  endtask

  initial begin
    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'h1234_5678,  64'h0};
    vecs[3] = '{32'h1234_5678,  32'd0,          64'h0};
    vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[7] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001};
    vecs[8] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[9] = '{32'd7,          32'd9,          64'd63};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);

    // Back-pressure with changing operands and in_valid held high.
    do_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 10, 1'b1);

    // Reset during RUN iteration 10, product holding a prior nonzero result.
    do_op(32'd3, 32'd5, 64'd15, 0, 1'b0);
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrun_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrun_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;
    do_op(32'd7, 32'd9, 64'd63, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (n % 7 == 0) ra = 32'hFFFF_FFFF;
      do_op(ra, rb, 64'(ra) * 64'(rb), $urandom_range(0, 5), n[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
